// File: rtl/datapath_sequencer_if.sv
// Request/strobe bundle between a requester, datapath_sequencer and the accumulator datapath.
// Define SEQ_ABORT_EN to add the abort request line.
interface datapath_sequencer_if #(
    parameter int unsigned CNT_W = 4
);
    logic             start;
    logic [1:0]       op;
    logic [CNT_W-1:0] count;
`ifdef SEQ_ABORT_EN
    logic             abort;
`endif
    logic             busy;
    logic             done;
    logic             RAin;
    logic             RBin;
    logic             RZin;
    logic             RAout;
    logic             RBout;
    logic             RZout;
    logic [CNT_W-1:0] iter_left;

`ifdef SEQ_ABORT_EN
    modport master (
        output start, op, count, abort,
        input  busy, done, RAin, RBin, RZin, RAout, RBout, RZout, iter_left
    );
    modport slave (
        input  start, op, count, abort,
        output busy, done, RAin, RBin, RZin, RAout, RBout, RZout, iter_left
    );
`else
    modport master (
        output start, op, count,
        input  busy, done, RAin, RBin, RZin, RAout, RBout, RZout, iter_left
    );
    modport slave (
        input  start, op, count,
        output busy, done, RAin, RBin, RZin, RAout, RBout, RZout, iter_left
    );
`endif
endinterface

// File: rtl/datapath_sequencer.sv
// Control-step FSM driving the RA/RB/RZ accumulator datapath strobes for LDA/MOVAB/ADDA/ADDB.
// Define SEQ_ABORT_EN to allow aborting an operation in T0/T1.
module datapath_sequencer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic                 clock,
    input  logic                 clear,
    datapath_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StT0, StT1, StDone} state_e;

    localparam logic [1:0] OpLda   = 2'd0;
    localparam logic [1:0] OpMovab = 2'd1;
    localparam logic [1:0] OpAdda  = 2'd2;
    localparam logic [1:0] OpAddb  = 2'd3;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             busy_q, done_q;
    logic [5:0]       strb_q;
    logic [CNT_W-1:0] iter_q;

    // Strobe vector order: {RAin, RBin, RZin, RAout, RBout, RZout}
    function automatic logic [5:0] decode(state_e s, logic [1:0] o);
        logic [5:0] v;
        v = '0;
        case (s)
            StT0: begin
                unique case (o)
                    OpLda:   v = 6'b100000;
                    OpMovab: v = 6'b010100;
                    OpAdda:  v = 6'b001100;
                    OpAddb:  v = 6'b001010;
                endcase
            end
            StT1:    v = 6'b010001;
            default: v = '0;
        endcase
        return v;
    endfunction

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    cnt_d   = (bus.op != OpAddb) ? CNT_W'(1) :
                              (bus.count == '0)  ? CNT_W'(1) : bus.count;
                    state_d = StT0;
                end
            end
            StT0: state_d = op_q[1] ? StT1 : StDone;
            StT1: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StDone;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = StT0;
                end
            end
            StDone: state_d = StIdle;
        endcase
`ifdef SEQ_ABORT_EN
        // Abort beats a same-edge completion out of T1.
        if (bus.abort && (state_q == StT0 || state_q == StT1)) begin
            state_d = StIdle;
            cnt_d   = cnt_q;
        end
`endif
    end

    // Outputs are registered from the next state so they stay a pure Moore decode.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= StIdle;
            op_q    <= OpLda;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            strb_q  <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != StIdle);
            done_q  <= (state_d == StDone);
            strb_q  <= decode(state_d, op_d);
            iter_q  <= (state_d == StIdle) ? '0 : cnt_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.RAin      = strb_q[5];
    assign bus.RBin      = strb_q[4];
    assign bus.RZin      = strb_q[3];
    assign bus.RAout     = strb_q[2];
    assign bus.RBout     = strb_q[1];
    assign bus.RZout     = strb_q[0];
    assign bus.iter_left = iter_q;

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Control-step FSM directly upstream of the accumulator datapath (RA/RB/RZ registers, adder, one-hot bus).
- Takes a start request with a 2-bit opcode and a repeat count.
- Drives the datapath's register-in strobes (RAin/RBin/RZin) and one-hot bus-out selects (RZout/RAout/RBout) through a fixed micro-step sequence.
- Reports busy/done to its requester.

Parameters:
- CNT_W, 4, width of the repeat-count input and internal iteration counter.

Ports:
- clock  input  1  rising-edge clock shared with the datapath
- clear  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  2  00=LDA (RA<-imm), 01=MOVAB (RB<-RA), 10=ADDA (RB<-A+RA), 11=ADDB (RB<-A+RB, repeated)
- count  input  CNT_W  ADDB iteration count; 0 treated as 1; ignored for other ops
- busy  output  1  high from the cycle after start is accepted until DONE ends
- done  output  1  one-cycle pulse at completion
- RAin, RBin, RZin  output  1 each  datapath register load strobes
- RAout, RBout, RZout  output  1 each  bus drive selects, at most one high
- iter_left  output  CNT_W  remaining ADDB iterations including the current one; 0 when idle

Behaviour:
- Reset (clear=0, async): state=IDLE; busy, done, all six strobes = 0; iter_left=0; latched op=00.
- States: IDLE, T0, T1, DONE. The state, latched op and counter are flops. Strobes are Moore decode of state plus latched op only; no start/op/count path to strobes.
- IDLE: if start=1 at edge k, latch op; load counter = (count==0 ? 1 : count) for ADDB, else 1; go to T0. busy=1 from cycle k+1.
- T0 strobes:
  - LDA: RAin.
  - MOVAB: RAout, RBin.
  - ADDA: RAout, RZin.
  - ADDB: RBout, RZin.
- T0 next state: LDA/MOVAB -> DONE; ADDA/ADDB -> T1.
- T1 strobes (ADDA/ADDB): RZout, RBin.
  - If counter==1 -> DONE.
  - Else decrement counter -> T0 (next accumulation uses the updated RB).
- DONE: done=1, busy=1, no strobes; -> IDLE. done and busy fall together on the next edge.
- Latency from accepting edge to done high, in cycles:
  - LDA/MOVAB: 2.
  - ADDA: 3.
  - ADDB with N iterations: 2N+1.
- start while not IDLE: ignored, no queuing. A new start is accepted in the cycle after DONE (IDLE). Back-to-back ops therefore have one idle cycle between them.
- op/count changes after acceptance have no effect.
- Invariants:
  - At most one of RAout/RBout/RZout high in any cycle.
  - An *in strobe and the *out of the same register are never high together.
  - No strobe is high in IDLE or DONE.
- Counter never underflows: the decrement occurs only when counter>1. Max iterations = 2^CNT_W - 1.
- Reset mid-operation: immediate return to IDLE with all strobes low. Datapath register contents are not restored.

Optional Feature:
- Macro SEQ_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 at any edge in T0/T1 -> IDLE next cycle; strobes deassert; done NOT pulsed; busy falls; iter_left=0.
  - abort is ignored in IDLE and DONE.
  - abort and a T1 completion at the same edge: abort wins.
- Undefined: no abort port; every accepted operation runs to DONE.

Test Plan:
- Reset: hold clear=0 two cycles mid-ADDB -> all strobes/busy/done=0, iter_left=0; release, no activity without start.
- LDA then MOVAB:
  - Datapath RegisterAImmediate=0x0000_0005; start op=00 -> RAin one cycle, done 2 cycles after accept.
  - Then op=01 -> RB=5, with RAout+RBin in the same cycle.
- ADDA: RA=5, A=3, op=10 -> T0 RAout+RZin, T1 RZout+RBin, RB=8, done at cycle 3.
- ADDB repeat: RB=0, A=7, op=11, count=4 -> RB=28, done at cycle 9, iter_left 4,3,2,1. count=0 -> single iteration, RB=7.
- start ignored: assert start op=00 during ADDB T1 -> no RAin; sequence unaffected; new start accepted only in IDLE.
- SEQ_ABORT_EN:
  - abort in the 2nd T0 of ADDB count=3 -> IDLE next cycle, no done, RB holds the value from iteration 1.
  - Without the macro, the same bench compiles without an abort port.
